// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a four-state FSM (FETCH, WAIT,
// HOLD, HALTED) feeding a single registered instruction slot to decode.
// Optional feature: define FETCH_PREFETCH_EN to let HOLD prefetch one word
// into a one-entry buffer so a stall release delivers the next instruction
// on the following edge.
//
// Handshakes:
//   memory : mem_req is a one-cycle pulse with mem_addr; exactly one request is
//            ever outstanding; mem_rdy/mem_data answer it one or more cycles
//            later. A response owed to a request issued before a redirect is
//            swallowed (discard flag) and no new request leaves until it lands.
//   decode : instr/pc are offered while instr_valid=1; the word is taken at an
//            edge where instr_valid=1 and stall=0, and held unchanged otherwise.
// dbg_state exposes the FSM state for checkers.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        halt,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] fetch_pc, fetch_pc_nxt;
  logic [15:0] instr_nxt, pc_nxt;
  logic        instr_valid_nxt, halted_nxt;
  logic        discard, discard_nxt;
  logic        issue;
  logic        consume;
  logic        outstanding;

`ifdef FETCH_PREFETCH_EN
  logic        pf_pending, pf_pending_nxt;
  logic        pf_valid, pf_valid_nxt;
  logic [15:0] pf_data, pf_data_nxt;
  logic [15:0] pf_pc, pf_pc_nxt;
`endif

  // Request decode: purely from registered state, never from redirect/stall.
  always_comb begin
    issue = 1'b0;
    if (!discard) begin
      if (state == S_FETCH) issue = 1'b1;
`ifdef FETCH_PREFETCH_EN
      if (state == S_HOLD && !pf_pending && !pf_valid) issue = 1'b1;
`endif
    end
  end

  // The request is masked while reset is held so nothing leaves during reset.
  assign mem_req   = issue & rst;
  assign mem_addr  = fetch_pc;
  assign pc_plus2  = pc + 16'd2;
  assign dbg_state = state;

  // Next-state and datapath updates, priority redirect > halt > stall > progress.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    instr_nxt       = instr;
    pc_nxt          = pc;
    instr_valid_nxt = instr_valid;
    halted_nxt      = halted;
    discard_nxt     = discard;
`ifdef FETCH_PREFETCH_EN
    pf_pending_nxt  = pf_pending;
    pf_valid_nxt    = pf_valid;
    pf_data_nxt     = pf_data;
    pf_pc_nxt       = pf_pc;
`endif
    consume = instr_valid && !stall;
    // A response will still arrive after this edge if a request goes out now,
    // or one is pending and is not being answered this cycle.
    outstanding = issue
               || (state == S_WAIT && !mem_rdy)
               || (discard && !mem_rdy);
`ifdef FETCH_PREFETCH_EN
    outstanding = outstanding || (pf_pending && !mem_rdy);
`endif

    if (state == S_HALTED) begin
      // Only reset leaves HALTED; every input is ignored here.
    end else if (redirect) begin
      fetch_pc_nxt    = next_pc;
      instr_valid_nxt = 1'b0;
      state_nxt       = S_FETCH;
      discard_nxt     = outstanding;
`ifdef FETCH_PREFETCH_EN
      pf_pending_nxt  = 1'b0;
      pf_valid_nxt    = 1'b0;
`endif
    end else if (halt) begin
      state_nxt       = S_HALTED;
      instr_valid_nxt = 1'b0;
      halted_nxt      = 1'b1;
      discard_nxt     = 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_pending_nxt  = 1'b0;
      pf_valid_nxt    = 1'b0;
`endif
    end else begin
      if (consume) instr_valid_nxt = 1'b0;
      case (state)
        S_FETCH: begin
          if (discard) begin
            // Waiting out a stale response before the redirected fetch.
            if (mem_rdy) discard_nxt = 1'b0;
          end else begin
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rdy) begin
            if (stall && instr_valid) begin
              // Decode still holds the previous word, so the slot is busy.
`ifdef FETCH_PREFETCH_EN
              pf_valid_nxt = 1'b1;
              pf_data_nxt  = mem_data;
              pf_pc_nxt    = fetch_pc;
              fetch_pc_nxt = fetch_pc + 16'd2;
`endif
              // Without a buffer the word is dropped; fetch_pc is not
              // advanced, so the same address is fetched again later.
              state_nxt = S_HOLD;
            end else begin
              instr_nxt       = mem_data;
              pc_nxt          = fetch_pc;
              instr_valid_nxt = 1'b1;
              fetch_pc_nxt    = fetch_pc + 16'd2;
              state_nxt       = stall ? S_HOLD : S_FETCH;
            end
          end
        end
        S_HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (issue) pf_pending_nxt = 1'b1;
          if (!stall) begin
            if (pf_valid) begin
              instr_nxt       = pf_data;
              pc_nxt          = pf_pc;
              instr_valid_nxt = 1'b1;
              pf_valid_nxt    = 1'b0;
              state_nxt       = S_FETCH;
            end else if (pf_pending && mem_rdy) begin
              instr_nxt       = mem_data;
              pc_nxt          = fetch_pc;
              instr_valid_nxt = 1'b1;
              fetch_pc_nxt    = fetch_pc + 16'd2;
              pf_pending_nxt  = 1'b0;
              state_nxt       = S_FETCH;
            end else if (pf_pending || issue) begin
              // Prefetch still in flight: WAIT collects it as a normal fetch.
              pf_pending_nxt  = 1'b0;
              state_nxt       = S_WAIT;
            end else begin
              state_nxt       = S_FETCH;
            end
          end else if (pf_pending && mem_rdy) begin
            pf_valid_nxt   = 1'b1;
            pf_data_nxt    = mem_data;
            pf_pc_nxt      = fetch_pc;
            fetch_pc_nxt   = fetch_pc + 16'd2;
            pf_pending_nxt = 1'b0;
          end
`else
          if (!stall) state_nxt = S_FETCH;
`endif
        end
        default: state_nxt = state;
      endcase
    end
  end

  // All state registers, asynchronously cleared while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      fetch_pc    <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      discard     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_pending  <= 1'b0;
      pf_valid    <= 1'b0;
      pf_data     <= 16'h0000;
      pf_pc       <= 16'h0000;
`endif
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= instr_valid_nxt;
      halted      <= halted_nxt;
      discard     <= discard_nxt;
`ifdef FETCH_PREFETCH_EN
      pf_pending  <= pf_pending_nxt;
      pf_valid    <= pf_valid_nxt;
      pf_data     <= pf_data_nxt;
      pf_pc       <= pf_pc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit. A memory model answers each request
// after a chosen latency with a word derived from its address; a program-order
// model (next expected pc) checks every word decode consumes.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] next_pc = 16'h0000;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rdy = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        halted;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect),
    .stall(stall), .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdy(mem_rdy), .mem_data(mem_data), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus2(pc_plus2),
    .halted(halted), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] exp_q[$];      // expected request addresses, in order
  logic [15:0] exp_pc;        // pc of the next word decode should receive
  logic        is_halted = 1'b0;
  logic        pend_valid = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          pend_cnt = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          n_req = 0;
  int          consumed = 0;
  logic        saw_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // One clock cycle: inputs already set at the negedge; returns at next negedge.
  task automatic step();
    logic        busy;
    logic        hold_now;
    logic [15:0] hold_pc;
    logic [15:0] hold_instr;
    logic [15:0] p2;
    busy     = pend_valid;
    mem_rdy  = 1'b0;
    mem_data = 16'h0000;
    if (pend_valid) begin
      if (pend_cnt <= 1) begin
        mem_rdy    = 1'b1;
        mem_data   = mem_word(pend_addr);
        pend_valid = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    saw_req = 1'b0;
    if (mem_req) begin
      saw_req = 1'b1;
      n_req++;
      check("one_outstanding", {31'b0, busy}, 32'd0);
      if (exp_q.size() > 0) check("req_addr", {16'b0, mem_addr}, {16'b0, exp_q.pop_front()});
      pend_valid = 1'b1;
      pend_addr  = mem_addr;
      pend_cnt   = $urandom_range(lat_hi, lat_lo);
    end
    if (instr_valid && !stall && !redirect && !halt) begin
      p2 = exp_pc + 16'd2;
      check("pc", {16'b0, pc}, {16'b0, exp_pc});
      check("instr", {16'b0, instr}, {16'b0, mem_word(exp_pc)});
      check("pc_plus2", {16'b0, pc_plus2}, {16'b0, p2});
      exp_pc = p2;
      consumed++;
    end
    hold_now   = instr_valid && stall && !redirect && !halt;
    hold_pc    = pc;
    hold_instr = instr;
    if (redirect && !is_halted) exp_pc = next_pc;
    if (halt && !redirect) is_halted = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rdy = 1'b0;
    if (hold_now) begin
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_pc", {16'b0, pc}, {16'b0, hold_pc});
      check("hold_instr", {16'b0, instr}, {16'b0, hold_instr});
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    mem_rdy = 1'b0; mem_data = 16'h0000; next_pc = 16'h0000;
    pend_valid = 1'b0; is_halted = 1'b0; exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", {16'b0, pc}, {16'b0, RESET_PC});
    check("rst_instr", {16'b0, instr}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    rst = 1'b1;
    exp_pc = RESET_PC;
    #1;
    check("first_req", {31'b0, mem_req}, 32'd1);
    check("first_addr", {16'b0, mem_addr}, {16'b0, RESET_PC});
  endtask

  task automatic run_until_consumed(input int n, input int budget, input string tag);
    int target;
    int k;
    target = consumed + n;
    k = 0;
    while (consumed < target && k < budget) begin
      step();
      k++;
    end
    check(tag, {31'b0, consumed >= target}, 32'd1);
  endtask

  task automatic run_until_reqs_done(input int budget, input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic run_until_req(input int budget, input string tag);
    int k;
    k = 0;
    saw_req = 1'b0;
    while (!saw_req && k < budget) begin
      step();
      k++;
    end
    check(tag, {31'b0, saw_req}, 32'd1);
  endtask

  initial begin
    int n0;
    int idle;
    int k;
    logic [15:0] np;

    // sequential fetch from reset, one-cycle memory
    lat_lo = 1; lat_hi = 1;
    do_reset();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004);
    run_until_consumed(3, 40, "seq_consume");
    check("seq_reqs", exp_q.size(), 32'd0);

    // wrap at the top of the address space
    redirect = 1'b1; next_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'h0000);
    run_until_consumed(2, 40, "wrap_consume");
    run_until_reqs_done(20, "wrap_reqs");

    // redirect while a slow response is outstanding
    lat_lo = 3; lat_hi = 3;
    run_until_req(20, "flush_req_seen");
    redirect = 1'b1; next_pc = 16'h0040;
    step();
    redirect = 1'b0;
    exp_q.push_back(16'h0040);
    k = 0;
    while (pend_valid && k < 10) begin
      check("flush_valid", {31'b0, instr_valid}, 32'd0);
      check("flush_noreq", {31'b0, mem_req}, 32'd0);
      step();
      k++;
    end
    check("flush_drained", {31'b0, pend_valid}, 32'd0);
    check("flush_valid_after", {31'b0, instr_valid}, 32'd0);
    run_until_reqs_done(20, "flush_next_addr");
    run_until_consumed(1, 20, "flush_consume");

    // stall held for five cycles on a valid instruction
    lat_lo = 1; lat_hi = 1;
    redirect = 1'b1; next_pc = 16'h0200; stall = 1'b1;
    step();
    redirect = 1'b0;
    k = 0;
    while (!instr_valid && k < 20) begin
      step();
      k++;
    end
    check("stall_valid", {31'b0, instr_valid}, 32'd1);
    check("stall_pc", {16'b0, pc}, 32'h0200);
    n0 = n_req;
    repeat (5) step();
`ifdef FETCH_PREFETCH_EN
    check("stall_reqs", n_req - n0, 32'd1);
`else
    check("stall_reqs", n_req - n0, 32'd0);
`endif
    stall = 1'b0;
    step();
`ifdef FETCH_PREFETCH_EN
    check("release_valid", {31'b0, instr_valid}, 32'd1);
    check("release_pc", {16'b0, pc}, 32'h0202);
`endif
    run_until_consumed(2, 40, "release_consume");

    // halt and redirect together: redirect wins
    halt = 1'b1; redirect = 1'b1; next_pc = 16'h0100;
    step();
    halt = 1'b0; redirect = 1'b0;
    check("hr_halted", {31'b0, halted}, 32'd0);
    exp_q.push_back(16'h0100);
    run_until_reqs_done(20, "hr_redirect");
    run_until_consumed(1, 20, "hr_consume");

    // halt alone, then nothing more for twenty cycles
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_flag", {31'b0, halted}, 32'd1);
    check("halt_valid", {31'b0, instr_valid}, 32'd0);
    n0 = n_req;
    for (int i = 0; i < 20; i++) begin
      stall = 1'($urandom_range(1, 0));
      redirect = (i % 5 == 2);
      next_pc = 16'h0800;
      step();
    end
    redirect = 1'b0; stall = 1'b0;
    check("halt_noreq", n_req - n0, 32'd0);
    check("halt_stays", {31'b0, halted}, 32'd1);
    check("halt_valid_stays", {31'b0, instr_valid}, 32'd0);

    // reset pulse restarts fetch
    do_reset();
    exp_q.push_back(RESET_PC);
    run_until_reqs_done(10, "restart_addr");
    run_until_consumed(1, 20, "restart_consume");

    // asynchronous reset in the middle of WAIT
    redirect = 1'b1; next_pc = 16'h0300;
    step();
    redirect = 1'b0;
    run_until_consumed(1, 20, "async_pre");
    lat_lo = 3; lat_hi = 3;
    run_until_req(20, "async_req_seen");
    #2;
    rst = 1'b0;
    #1;
    check("async_pc", {16'b0, pc}, {16'b0, RESET_PC});
    check("async_instr", {16'b0, instr}, 32'd0);
    check("async_valid", {31'b0, instr_valid}, 32'd0);
    check("async_req", {31'b0, mem_req}, 32'd0);
    check("async_pc_plus2", {16'b0, pc_plus2}, 32'h0002);
    @(negedge clk);
    do_reset();

    // randomized traffic: stalls, variable latency, occasional redirects
    lat_lo = 1; lat_hi = 4;
    idle = 0;
    for (int i = 0; i < 3000; i++) begin
      n0 = consumed;
      stall = ($urandom_range(99, 0) < 30);
      redirect = ($urandom_range(99, 0) < 3);
      np = 16'($urandom_range(65535, 0)) & 16'hFFFE;
      next_pc = np;
      step();
      if (consumed == n0) idle++; else idle = 0;
      if (idle > 200) begin
        check("liveness", 32'd0, 32'd1);
        break;
      end
    end
    redirect = 1'b0; stall = 1'b0;
    check("random_progress", {31'b0, consumed > 500}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
